// File: rtl/k423_id_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// k423_id_scoreboard_pkg
// Shared constants for the ID-stage register scoreboard.
//   NUM_ARCH_REGS : number of architectural integer registers (x0..x31)
//   SB_CNT_W      : default width of each per-register pending-write counter
//   INST_RSDIDX_W : width of a register index (also provided as a macro)
// -----------------------------------------------------------------------------
`ifndef INST_RSDIDX_W
`define INST_RSDIDX_W 5
`endif

package k423_id_scoreboard_pkg;

  localparam int NUM_ARCH_REGS = 32;
  localparam int SB_CNT_W      = 2;
  localparam int INST_RSDIDX_W = `INST_RSDIDX_W;

endpackage

// File: rtl/k423_id_scoreboard_if.sv
// -----------------------------------------------------------------------------
// k423_id_scoreboard_if
// Bundles the ID-stage handshake, the register read/write requests and the
// writeback port seen by the scoreboard.
//   master : the pipeline side (drives requests, observes done/issue)
//   slave  : the scoreboard (observes requests, drives done/issue)
// -----------------------------------------------------------------------------
`ifndef INST_RSDIDX_W
`define INST_RSDIDX_W 5
`endif

interface k423_id_scoreboard_if;

  logic                      if_stage_vld_i;
  logic                      ex_stage_rdy_i;
  logic                      flush_i;
  logic                      rs1_vld_i;
  logic [`INST_RSDIDX_W-1:0] rs1_idx_i;
  logic                      rs2_vld_i;
  logic [`INST_RSDIDX_W-1:0] rs2_idx_i;
  logic                      rd_vld_i;
  logic [`INST_RSDIDX_W-1:0] rd_idx_i;
  logic                      wb_vld_i;
  logic [`INST_RSDIDX_W-1:0] wb_idx_i;
  logic                      id_stage_done_o;
  logic                      issue_o;

  modport master (
    output if_stage_vld_i, ex_stage_rdy_i, flush_i,
    output rs1_vld_i, rs1_idx_i, rs2_vld_i, rs2_idx_i,
    output rd_vld_i, rd_idx_i, wb_vld_i, wb_idx_i,
    input  id_stage_done_o, issue_o
  );

  modport slave (
    input  if_stage_vld_i, ex_stage_rdy_i, flush_i,
    input  rs1_vld_i, rs1_idx_i, rs2_vld_i, rs2_idx_i,
    input  rd_vld_i, rd_idx_i, wb_vld_i, wb_idx_i,
    output id_stage_done_o, issue_o
  );

endinterface

// File: rtl/k423_sb_cnt.sv
// -----------------------------------------------------------------------------
// k423_sb_cnt
// One saturating up/down pending-write counter.
//   clk   : clock
//   rst_n : synchronous active-low clear
//   inc   : one more in-flight write to this register
//   dec   : one in-flight write retires
//   cnt   : current count
//   nz    : count is non-zero
// Simultaneous inc and dec cancel. The count never wraps in either direction.
// -----------------------------------------------------------------------------
module k423_sb_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             nz
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // NOTE: sequential state is only ever written with non-blocking assignments
  // so every counter samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && !dec && cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec && !inc && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign nz = (cnt != '0);

  // A writeback for a register with nothing in flight is a pipeline bug.
  a_no_underflow : assert property (
    @(posedge clk) disable iff (!rst_n) !(dec && !inc && cnt == '0)
  );

endmodule

// File: rtl/k423_id_scoreboard.sv
// -----------------------------------------------------------------------------
// k423_id_scoreboard
// Tracks in-flight register writes per architectural register and holds the
// ID-stage instruction while a source (RAW) or destination (WAW saturation)
// hazard exists.
//   clk_i     : core clock
//   rst_n_i   : synchronous active-low reset
//   sb        : ID handshake, rs1/rs2/rd requests, writeback, done/issue
//   busy_o    : some register has a write in flight
//   pending_o : bit i set while xi has a write in flight (bit 0 always 0)
// Parameters:
//   CNT_W     : counter width; up to 2^CNT_W-1 writes in flight per register
//   WB_BYPASS : a same-cycle writeback releases a source whose count is 1
// -----------------------------------------------------------------------------
`ifndef INST_RSDIDX_W
`define INST_RSDIDX_W 5
`endif

module k423_id_scoreboard
  import k423_id_scoreboard_pkg::*;
#(
  parameter int CNT_W     = SB_CNT_W,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  k423_id_scoreboard_if.slave      sb,
  output logic                     busy_o,
  output logic [NUM_ARCH_REGS-1:0] pending_o
);

  localparam int               IDX_W   = `INST_RSDIDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]         cnt [NUM_ARCH_REGS];
  logic [NUM_ARCH_REGS-1:1] inc_vec;
  logic [NUM_ARCH_REGS-1:1] dec_vec;
  logic [NUM_ARCH_REGS-1:1] nz_vec;

  logic [CNT_W-1:0] rs1_cnt;
  logic [CNT_W-1:0] rs2_cnt;
  logic [CNT_W-1:0] rd_cnt;
  logic             rs1_haz;
  logic             rs2_haz;
  logic             rd_haz;
  logic             done;
  logic             issue;

  // x0 is hard-wired zero, so its slot reads as "nothing in flight".
  assign cnt[0] = '0;

  // A source must wait while a write to it is in flight, unless the last such
  // write is retiring this very cycle and the register file forwards it.
  function automatic logic src_hazard(
    input logic             vld,
    input logic [IDX_W-1:0] idx,
    input logic [CNT_W-1:0] c,
    input logic             wbv,
    input logic [IDX_W-1:0] wbi
  );
    logic bypass;
    bypass = WB_BYPASS && (c == CNT_W'(1)) && wbv && (wbi == idx);
    return vld && (idx != '0) && (c != '0) && !bypass;
  endfunction

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here straight-line), otherwise synthesis infers a latch.
  always_comb begin
    rs1_cnt = cnt[sb.rs1_idx_i];
    rs2_cnt = cnt[sb.rs2_idx_i];
    rd_cnt  = cnt[sb.rd_idx_i];

    rs1_haz = src_hazard(sb.rs1_vld_i, sb.rs1_idx_i, rs1_cnt,
                         sb.wb_vld_i, sb.wb_idx_i);
    rs2_haz = src_hazard(sb.rs2_vld_i, sb.rs2_idx_i, rs2_cnt,
                         sb.wb_vld_i, sb.wb_idx_i);
    // Issuing another write to a saturated register would overflow it.
    rd_haz  = sb.rd_vld_i && (sb.rd_idx_i != '0) && (rd_cnt == CNT_MAX);

    // While reset is held the counters are being cleared, so report a clean
    // scoreboard and never issue.
    done  = !rst_n_i || !(rs1_haz || rs2_haz || rd_haz);
    issue = rst_n_i && sb.if_stage_vld_i && done && sb.ex_stage_rdy_i
            && !sb.flush_i;
  end

  assign sb.id_stage_done_o = done;
  assign sb.issue_o         = issue;

  for (genvar i = 1; i < NUM_ARCH_REGS; i++) begin : g_cnt
    assign inc_vec[i] = issue && sb.rd_vld_i && (sb.rd_idx_i == IDX_W'(i));
    // Writebacks keep retiring during a flush: tracked writes are all older.
    assign dec_vec[i] = sb.wb_vld_i && (sb.wb_idx_i == IDX_W'(i));

    k423_sb_cnt #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk_i),
      .rst_n (rst_n_i),
      .inc   (inc_vec[i]),
      .dec   (dec_vec[i]),
      .cnt   (cnt[i]),
      .nz    (nz_vec[i])
    );
  end

  assign pending_o = {nz_vec, 1'b0};
  assign busy_o    = |nz_vec;

endmodule

// File: tb/tb_k423_id_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_k423_id_scoreboard
// Directed vectors with hand-computed expectations for the ID scoreboard.
// Inputs are driven just after the falling edge; outputs are compared 1 ns
// later, so done/issue reflect this vector and busy/pending reflect the state
// left by the previous rising edge. A second instance with WB_BYPASS=0 covers
// the no-forwarding variant.
// -----------------------------------------------------------------------------
module tb_k423_id_scoreboard;
  import k423_id_scoreboard_pkg::*;

  typedef struct {
    logic        rst;
    logic        ifv, exr, fl;
    logic        r1v;  logic [4:0] r1;
    logic        r2v;  logic [4:0] r2;
    logic        rdv;  logic [4:0] rd;
    logic        wbv;  logic [4:0] wb;
    logic        e_done, e_issue, e_busy;
    logic [31:0] e_pend;
  } vec_t;

  logic clk;
  logic rst_n;
  logic busy, busy2;
  logic [NUM_ARCH_REGS-1:0] pending, pending2;

  int n_vec  = 0;
  int n_chk  = 0;
  int n_fail = 0;

  vec_t tbl[$];

  k423_id_scoreboard_if sb ();
  k423_id_scoreboard_if sb2 ();

  k423_id_scoreboard #(.CNT_W(SB_CNT_W), .WB_BYPASS(1'b1)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .sb        (sb.slave),
    .busy_o    (busy),
    .pending_o (pending)
  );

  k423_id_scoreboard #(.CNT_W(SB_CNT_W), .WB_BYPASS(1'b0)) dut_nobyp (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .sb        (sb2.slave),
    .busy_o    (busy2),
    .pending_o (pending2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic rst, input logic ifv, input logic exr, input logic fl,
    input logic r1v, input int r1, input logic r2v, input int r2,
    input logic rdv, input int rd, input logic wbv, input int wb,
    input logic e_done, input logic e_issue, input logic e_busy,
    input logic [31:0] e_pend
  );
    vec_t v;
    v.rst = rst; v.ifv = ifv; v.exr = exr; v.fl = fl;
    v.r1v = r1v; v.r1 = 5'(r1); v.r2v = r2v; v.r2 = 5'(r2);
    v.rdv = rdv; v.rd = 5'(rd); v.wbv = wbv; v.wb = 5'(wb);
    v.e_done = e_done; v.e_issue = e_issue; v.e_busy = e_busy;
    v.e_pend = e_pend;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n             = v.rst;
    sb.if_stage_vld_i = v.ifv;
    sb.ex_stage_rdy_i = v.exr;
    sb.flush_i        = v.fl;
    sb.rs1_vld_i      = v.r1v;
    sb.rs1_idx_i      = v.r1;
    sb.rs2_vld_i      = v.r2v;
    sb.rs2_idx_i      = v.r2;
    sb.rd_vld_i       = v.rdv;
    sb.rd_idx_i       = v.rd;
    sb.wb_vld_i       = v.wbv;
    sb.wb_idx_i       = v.wb;
  endtask

  task automatic idle2();
    sb2.if_stage_vld_i = 1'b0; sb2.ex_stage_rdy_i = 1'b0; sb2.flush_i = 1'b0;
    sb2.rs1_vld_i = 1'b0; sb2.rs1_idx_i = '0;
    sb2.rs2_vld_i = 1'b0; sb2.rs2_idx_i = '0;
    sb2.rd_vld_i  = 1'b0; sb2.rd_idx_i  = '0;
    sb2.wb_vld_i  = 1'b0; sb2.wb_idx_i  = '0;
  endtask

  initial begin
    vec_t idle;
    idle = mk(1,0,0,0, 0,0, 0,0, 0,0, 0,0, 1,0,0,0);

    // rst ifv exr fl | r1v r1 | r2v r2 | rdv rd | wbv wb || done iss busy pend
    tbl.push_back(mk(0,1,1,0, 1,5,  0,0,  1,5,  0,0,  1,0,0,32'h0));        // reset holds
    tbl.push_back(mk(1,1,1,0, 0,0,  0,0,  1,5,  0,0,  1,1,0,32'h0));        // issue rd=x5
    tbl.push_back(mk(1,1,1,0, 1,5,  0,0,  0,0,  0,0,  0,0,1,32'h20));       // RAW on x5
    tbl.push_back(mk(1,1,1,0, 1,5,  0,0,  0,0,  1,5,  1,1,1,32'h20));       // wb bypass
    tbl.push_back(mk(1,0,1,0, 1,5,  0,0,  0,0,  0,0,  1,0,0,32'h0));        // no valid: no issue
    tbl.push_back(mk(1,1,1,0, 0,0,  0,0,  1,7,  0,0,  1,1,0,32'h0));        // x7 -> 1
    tbl.push_back(mk(1,1,1,0, 0,0,  0,0,  1,7,  0,0,  1,1,1,32'h80));       // x7 -> 2
    tbl.push_back(mk(1,1,1,0, 0,0,  0,0,  1,7,  0,0,  1,1,1,32'h80));       // x7 -> 3
    tbl.push_back(mk(1,1,1,0, 0,0,  0,0,  1,7,  0,0,  0,0,1,32'h80));       // WAW saturated
    tbl.push_back(mk(1,1,1,0, 0,0,  0,0,  1,7,  1,7,  0,0,1,32'h80));       // still blocked, x7 -> 2
    tbl.push_back(mk(1,1,1,0, 0,0,  0,0,  1,7,  0,0,  1,1,1,32'h80));       // x7 -> 3
    tbl.push_back(mk(1,0,0,0, 0,0,  0,0,  0,0,  1,7,  1,0,1,32'h80));       // x7 -> 2
    tbl.push_back(mk(1,0,0,0, 0,0,  0,0,  0,0,  1,7,  1,0,1,32'h80));       // x7 -> 1
    tbl.push_back(mk(1,0,0,0, 0,0,  0,0,  0,0,  1,7,  1,0,1,32'h80));       // x7 -> 0
    tbl.push_back(mk(1,1,1,0, 0,0,  0,0,  1,9,  0,0,  1,1,0,32'h0));        // x9 -> 1
    tbl.push_back(mk(1,1,1,0, 0,0,  0,0,  1,9,  1,9,  1,1,1,32'h200));      // inc+dec cancel
    tbl.push_back(idle_with(idle, 1'b1, 32'h200));                          // x9 still 1
    tbl.push_back(mk(1,1,1,0, 0,0,  1,9,  0,0,  1,9,  1,1,1,32'h200));      // rs2 bypass, x9 -> 0
    tbl.push_back(idle);
    tbl.push_back(mk(1,1,1,0, 1,0,  0,0,  1,0,  0,0,  1,1,0,32'h0));        // x0 untracked
    tbl.push_back(idle);
    tbl.push_back(mk(1,1,0,0, 0,0,  0,0,  1,3,  0,0,  1,0,0,32'h0));        // EX not ready
    tbl.push_back(mk(1,1,1,0, 0,0,  0,0,  1,3,  0,0,  1,1,0,32'h0));        // x3 -> 1
    tbl.push_back(mk(1,1,1,0, 0,0,  0,0,  1,3,  0,0,  1,1,1,32'h8));        // x3 -> 2
    tbl.push_back(mk(1,1,1,0, 0,0,  0,0,  1,4,  0,0,  1,1,1,32'h8));        // x4 -> 1
    tbl.push_back(mk(1,1,1,1, 0,0,  0,0,  1,3,  1,4,  1,0,1,32'h18));       // flush; wb x4 applies
    tbl.push_back(idle_with(idle, 1'b1, 32'h8));                            // x3 = 2, x4 = 0
    tbl.push_back(mk(1,1,1,0, 1,3,  0,0,  0,0,  1,3,  0,0,1,32'h8));        // count 2: no bypass
    tbl.push_back(mk(1,1,1,0, 0,0,  0,0,  1,3,  0,0,  1,1,1,32'h8));        // x3 back to 2
    tbl.push_back(mk(0,1,1,0, 0,0,  0,0,  1,3,  0,0,  1,0,1,32'h8));        // mid-run reset
    tbl.push_back(idle);                                                    // all cleared
    tbl.push_back(mk(1,1,1,0, 1,3,  0,0,  0,0,  0,0,  1,1,0,32'h0));        // no residual x3
    tbl.push_back(mk(1,1,1,0, 0,0,  0,0,  1,31, 0,0,  1,1,0,32'h0));        // x31 -> 1
    tbl.push_back(mk(1,1,1,0, 1,31, 1,31, 0,0,  0,0,  0,0,1,32'h8000_0000));// both sources hazarded
    tbl.push_back(mk(1,0,1,0, 1,31, 1,31, 0,0,  1,31, 1,0,1,32'h8000_0000));// bypass both, x31 -> 0
    tbl.push_back(idle);

    drive(mk(0,0,0,0, 0,0, 0,0, 0,0, 0,0, 1,0,0,0));
    idle2();
    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      n_vec++;
      check($sformatf("v%0d done", i),    32'(sb.id_stage_done_o), 32'(tbl[i].e_done));
      check($sformatf("v%0d issue", i),   32'(sb.issue_o),         32'(tbl[i].e_issue));
      check($sformatf("v%0d busy", i),    32'(busy),               32'(tbl[i].e_busy));
      check($sformatf("v%0d pending", i), pending,                 tbl[i].e_pend);
    end

    // Without forwarding, a retiring write does not release a dependent read.
    @(negedge clk);
    drive(idle);
    sb2.if_stage_vld_i = 1'b1; sb2.ex_stage_rdy_i = 1'b1;
    sb2.rd_vld_i = 1'b1; sb2.rd_idx_i = 5'd5;
    #1; n_vec++;
    check("nobyp issue rd=x5", 32'(sb2.issue_o), 32'd1);
    check("nobyp pending before", pending2, 32'h0);

    @(negedge clk);
    sb2.rd_vld_i = 1'b0; sb2.rd_idx_i = '0;
    sb2.rs1_vld_i = 1'b1; sb2.rs1_idx_i = 5'd5;
    sb2.wb_vld_i = 1'b1; sb2.wb_idx_i = 5'd5;
    #1; n_vec++;
    check("nobyp done with wb", 32'(sb2.id_stage_done_o), 32'd0);
    check("nobyp issue with wb", 32'(sb2.issue_o), 32'd0);
    check("nobyp pending x5", pending2, 32'h20);

    @(negedge clk);
    sb2.wb_vld_i = 1'b0; sb2.wb_idx_i = '0;
    #1; n_vec++;
    check("nobyp done after wb", 32'(sb2.id_stage_done_o), 32'd1);
    check("nobyp issue after wb", 32'(sb2.issue_o), 32'd1);
    check("nobyp pending after wb", pending2, 32'h0);
    check("nobyp busy after wb", 32'(busy2), 32'd0);

    @(negedge clk);
    idle2();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  function automatic vec_t idle_with(input vec_t base, input logic e_busy,
                                     input logic [31:0] e_pend);
    vec_t v;
    v = base;
    v.e_busy = e_busy;
    v.e_pend = e_pend;
    return v;
  endfunction

endmodule

// File: doc/k423_id_scoreboard.md
K423_ID_SCOREBOARD -- requirements
Module: k423_id_scoreboard

Interface
REQ-001 Parameter CNT_W, default 2: width of each per-register pending-write counter; maximum count is 2^CNT_W-1.
REQ-002 Parameter WB_BYPASS, default 1: when 1, a writeback in the current cycle satisfies a source whose count is 1.
REQ-003 clk_i  input  1  core clock; the only clock.
REQ-004 rst_n_i  input  1  reset; synchronous, active-low.
REQ-005 if_stage_vld_i  input  1  ID holds a valid decoded instruction.
REQ-006 ex_stage_rdy_i  input  1  EX can accept an instruction this cycle.
REQ-007 flush_i  input  1  kill the instruction in ID this cycle.
REQ-008 rs1_vld_i / rs1_idx_i  input  1 / `INST_RSDIDX_W  rs1 read request and index.
REQ-009 rs2_vld_i / rs2_idx_i  input  1 / `INST_RSDIDX_W  rs2 read request and index.
REQ-010 rd_vld_i / rd_idx_i  input  1 / `INST_RSDIDX_W  destination write request and index.
REQ-011 wb_vld_i / wb_idx_i  input  1 / `INST_RSDIDX_W  register-file write retiring this cycle.
REQ-012 id_stage_done_o  output  1  no hazard; the ID instruction may issue.
REQ-013 issue_o  output  1  the ID instruction issues to EX this cycle.
REQ-014 busy_o  output  1  at least one counter is non-zero.
REQ-015 pending_o  output  32  bit i set when counter i is non-zero.

Function
REQ-016 There SHALL be 31 counters, one for each of x1..x31; x0 is never tracked, and pending_o[0] is constant 0.
REQ-017 A source is hazarded when all of the following hold: its vld is set, its idx is not 0, and its counter is non-zero.
- Exception when WB_BYPASS=1: the source is not hazarded if its counter is 1, wb_vld_i is set, and wb_idx_i equals the source idx.
REQ-018 The destination is hazarded when rd_vld_i is set, rd_idx_i is not 0, and its counter equals the maximum (WAW saturation).
REQ-019 id_stage_done_o SHALL be the combinational NOR of the rs1, rs2 and rd hazards; this is zero added latency.
REQ-020 issue_o = if_stage_vld_i & id_stage_done_o & ex_stage_rdy_i & ~flush_i.
REQ-021 On issue_o with rd_vld_i set and rd_idx_i not 0, counter[rd_idx_i] SHALL increment at the next clock edge.
REQ-022 On wb_vld_i with wb_idx_i not 0, counter[wb_idx_i] SHALL decrement at the next clock edge.
REQ-023 When the increment and the decrement target the same index in the same cycle, that counter SHALL be unchanged.
REQ-024 A decrement of a zero counter SHALL be ignored (no underflow), and an assertion SHALL fire.
REQ-025 The increment can never overflow, because REQ-018 blocks issue at saturation.
REQ-026 flush_i SHALL suppress only this cycle's increment.
- Writebacks are still applied during flush_i.
- Flushes originate from EX, so all tracked instructions are older than the flush and still retire.
REQ-027 When if_stage_vld_i=0, issue_o SHALL be 0 and id_stage_done_o SHALL still reflect the current inputs.
REQ-028 busy_o and pending_o SHALL be registered-state derived, combinational from the counters.

Reset
REQ-029 While rst_n_i=0 at a clock edge, all counters SHALL clear to 0.
REQ-030 Reset values: pending_o=0, busy_o=0, issue_o=0; id_stage_done_o=1 for any inputs.
REQ-031 Reset asserted mid-operation SHALL discard all pending state, with no residual counts after release.

Structure
REQ-032 NUM_ARCH_REGS (32) and SB_CNT_W (2) SHALL be defined in the shared defines/package; indices use `INST_RSDIDX_W.
REQ-033 One sub-module, k423_sb_cnt, SHALL implement one saturating up/down counter with inc/dec inputs and a nz output; it is instantiated 31 times via generate.

Verification
REQ-034 After reset, issue rd=x5 with ex_stage_rdy_i=1 -> next cycle pending_o=0x20 and busy_o=1.
REQ-035 Next cycle, an instruction with rs1=x5 and no writeback -> id_stage_done_o=0 and issue_o=0; assert wb_vld_i with wb_idx_i=5 in the same cycle -> id_stage_done_o=1, and pending_o=0 on the following cycle.
REQ-036 Issue rd=x7 three consecutive times -> counter=3; a fourth rd=x7 -> id_stage_done_o=0 until one wb_idx_i=7 arrives.
REQ-037 Counter[x9]=1, with issue rd=x9 and wb_idx_i=9 in the same cycle -> counter stays 1 and pending_o[9]=1.
REQ-038 rd=x0 issued and rs1=x0 read -> no counter change and id_stage_done_o=1.
REQ-039 Counters x3=2 and x4=1, then flush_i=1 with a valid rd=x3 in ID -> issue_o=0 and x3 stays 2; rst_n_i=0 for one cycle -> pending_o=0 and busy_o=0.
